// File: rtl/always_clock.sv
// Bitwise a ^ b produced three ways: continuous assign, always_comb and a clocked register.
// Combinational outputs have zero latency; out_always_ff lags by one clk and only it sees rst.
module always_clock #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output wire  [WIDTH-1:0] out_assign,
   output logic [WIDTH-1:0] out_always_comb,
   output logic [WIDTH-1:0] out_always_ff
);

   assign out_assign = a ^ b;

   always_comb begin
      out_always_comb = a ^ b;
   end

   // Reset is deliberately confined to the registered copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_always_ff <= '0;
      end else begin
         out_always_ff <= a ^ b;
      end
   end

endmodule

// File: tb/tb_always_clock.sv
// Directed bench for always_clock at WIDTH=1 and WIDTH=8 with hand-computed expectations.
module tb_always_clock;

   logic       clk;
   logic       rst;
   logic       a, b;
   logic [7:0] a8, b8;
   wire        o_asg;
   logic       o_comb, o_ff;
   wire  [7:0] o_asg8;
   logic [7:0] o_comb8, o_ff8;

   int checks   = 0;
   int failures = 0;

   always_clock #(.WIDTH(1)) u_dut1 (
      .clk             (clk),
      .rst             (rst),
      .a               (a),
      .b               (b),
      .out_assign      (o_asg),
      .out_always_comb (o_comb),
      .out_always_ff   (o_ff)
   );

   always_clock #(.WIDTH(8)) u_dut8 (
      .clk             (clk),
      .rst             (rst),
      .a               (a8),
      .b               (b8),
      .out_assign      (o_asg8),
      .out_always_comb (o_comb8),
      .out_always_ff   (o_ff8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      a   = 1'b0;
      b   = 1'b1;
      a8  = 8'hA5;
      b8  = 8'h0F;
      #1;
      check("comb_t0_assign", {7'b0, o_asg}, 8'h01);
      check("comb_t0_comb",   {7'b0, o_comb}, 8'h01);

      #2;
      a = 1'b1;
      b = 1'b0;
      #1;
      check("comb_swap_assign", {7'b0, o_asg}, 8'h01);
      check("comb_swap_comb",   {7'b0, o_comb}, 8'h01);

      // Two reset edges with a=0, b=1.
      a   = 1'b0;
      b   = 1'b1;
      rst = 1'b1;
      step();
      check("rst1_ff",     {7'b0, o_ff}, 8'h00);
      check("rst1_assign", {7'b0, o_asg}, 8'h01);
      check("rst1_comb",   {7'b0, o_comb}, 8'h01);
      check("rst1_ff8",    o_ff8, 8'h00);
      step();
      check("rst2_ff",     {7'b0, o_ff}, 8'h00);
      check("rst2_comb",   {7'b0, o_comb}, 8'h01);

      // Toggle a with b=0: register follows one edge later.
      rst = 1'b0;
      a   = 1'b1;
      b   = 1'b0;
      #1;
      check("tog_pre_ff", {7'b0, o_ff}, 8'h00);
      check("tog_assign", {7'b0, o_asg}, 8'h01);
      step();
      check("tog1_ff", {7'b0, o_ff}, 8'h01);
      check("w8_ff",   o_ff8, 8'hAA);
      check("w8_asg",  o_asg8, 8'hAA);
      check("w8_comb", o_comb8, 8'hAA);
      a = 1'b0;
      #1;
      check("tog_mid_ff",     {7'b0, o_ff}, 8'h01);
      check("tog_mid_assign", {7'b0, o_asg}, 8'h00);
      step();
      check("tog2_ff", {7'b0, o_ff}, 8'h00);
      a = 1'b1;
      step();
      check("tog3_ff", {7'b0, o_ff}, 8'h01);

      // Equal operands give zero; register holds until the edge.
      a = 1'b1;
      b = 1'b1;
      #1;
      check("eq11_assign", {7'b0, o_asg}, 8'h00);
      check("eq11_comb",   {7'b0, o_comb}, 8'h00);
      check("eq11_ff_hold", {7'b0, o_ff}, 8'h01);
      a = 1'b0;
      b = 1'b0;
      #1;
      check("eq00_assign", {7'b0, o_asg}, 8'h00);
      check("eq00_comb",   {7'b0, o_comb}, 8'h00);
      check("eq00_ff_hold", {7'b0, o_ff}, 8'h01);
      step();
      check("eq00_ff", {7'b0, o_ff}, 8'h00);

      // Mid-cycle change away from the edge.
      #2;
      a = 1'b1;
      #1;
      check("mid_ff_hold", {7'b0, o_ff}, 8'h00);
      check("mid_assign",  {7'b0, o_asg}, 8'h01);
      check("mid_comb",    {7'b0, o_comb}, 8'h01);
      step();
      check("mid_ff", {7'b0, o_ff}, 8'h01);

      // Second 8-bit pattern, then reset mid-operation.
      a8 = 8'h3C;
      b8 = 8'hFF;
      #1;
      check("w8b_asg",     o_asg8, 8'hC3);
      check("w8b_ff_hold", o_ff8, 8'hAA);
      step();
      check("w8b_ff", o_ff8, 8'hC3);
      rst = 1'b1;
      #1;
      check("rst_mid_ff8_hold", o_ff8, 8'hC3);
      step();
      check("rst_mid_ff8",  o_ff8, 8'h00);
      check("rst_mid_ff",   {7'b0, o_ff}, 8'h00);
      check("rst_mid_asg8", o_asg8, 8'hC3);
      rst = 1'b0;
      step();
      check("post_rst_ff8", o_ff8, 8'hC3);
      check("post_rst_ff",  {7'b0, o_ff}, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
